gps_iq_collector: RTL and testbench

//  Downstream companion to one GPS/E1B demodulator channel. On each code epoch (ms0), it drives
//  the channel's serial IQ shift port and deserialises the 6 accumulators (ip,qp,ie,qe,il,ql).

---
 rtl/gps_iq_collector.sv | 150 +++++++++++++++
 tb/tb_gps_iq_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_iq_collector.sv
// Epoch-driven deserialiser for one demodulator channel's serial IQ port; complete
// 6-word records are queued in a small FIFO and read out word by word.
module gps_iq_collector #(
  parameter int INTEG_BITS = 20,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ms0,
  input  logic                     sout,
  output logic                     shift,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_data,
  output logic [2:0]               m_idx,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               ovr_cnt,
  input  logic                     ovr_clr
);

  localparam int W  = INTEG_BITS;
  localparam int NB = 6 * W;
  localparam int BW = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, PUSH} state_t;

  state_t                state, state_nxt;
  logic                  shift_nxt;
  logic                  push;
  logic                  pop;
  logic                  inc_ovr;
  logic                  full;
  logic [BW-1:0]         bcnt;
  logic [NB-1:0]         stage;
  logic [NB-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [NB-1:0]         head;
  logic signed [W-1:0]   head_word;

  assign full    = (fill == (AW + 1)'(DEPTH));
  assign m_valid = (fill != '0);
  assign m_last  = (m_idx == 3'd5);
  assign pop     = m_valid && m_ready && m_last;

  // A disabled collector always wins; otherwise a new epoch restarts capture and
  // throws away whatever was staged, since the demod has already reloaded.
  always_comb begin
    state_nxt = state;
    shift_nxt = 1'b0;
    push      = 1'b0;
    inc_ovr   = 1'b0;
    case (state)
      IDLE: begin
        if (en && ms0) state_nxt = WAIT;
      end
      WAIT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (ms0) begin
          inc_ovr = 1'b1;
        end else begin
          state_nxt = SHIFT;
          shift_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (ms0) begin
          state_nxt = WAIT;
          inc_ovr   = 1'b1;
        end else if (bcnt == BW'(NB - 1)) begin
          state_nxt = PUSH;
        end else begin
          shift_nxt = 1'b1;
        end
      end
      PUSH: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (ms0) begin
          state_nxt = WAIT;
          inc_ovr   = 1'b1;
        end else begin
          state_nxt = IDLE;
          if (!full || pop) push = 1'b1;
          else              inc_ovr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      stage <= '0;
    end else begin
      if (state == WAIT)       bcnt <= '0;
      else if (state == SHIFT) bcnt <= bcnt + 1'b1;
      if (state == SHIFT)      stage <= {stage[NB-2:0], sout};
    end
  end

  // Record storage needs no reset: visibility is governed entirely by fill.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stage;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      m_idx  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
      if (m_valid && m_ready) m_idx <= m_last ? 3'd0 : m_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ovr_clr)                  ovr_cnt <= '0;
    else if (inc_ovr && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end

  // Word 0 (ip) was shifted in first, so it sits in the top W bits of a record.
  always_comb begin
    head      = mem[rd_ptr];
    head_word = head[(5 - int'(m_idx)) * W +: W];
    m_data    = m_valid ? 32'(head_word) : 32'd0;
  end

endmodule

// File: tb/tb_gps_iq_collector.sv
// Bench for gps_iq_collector: behavioural demod shift register plus a word scoreboard
// fed per captured epoch and emptied by a monitor on every output handshake.
module tb_gps_iq_collector;

  localparam int W  = 20;
  localparam int NB = 6 * W;

  typedef struct {
    logic [NB-1:0] rec;
    logic [31:0]   exp [6];
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, ms0, sout, shift, m_valid, m_ready, m_last, ovr_clr;
  logic [31:0] m_data;
  logic [2:0]  m_idx;
  logic [2:0]  fill;
  logic [7:0]  ovr_cnt;

  vec_t        vecs [6];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ready_mode = 1;
  int          track_from = 32'h3FFF_FFFF;
  int          sh_first, sh_last, sh_cnt, v_first;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_i;
  int          n, n2;

  logic          ms0_d1 = 1'b0;
  logic [NB-1:0] ser_iq = '0;
  logic [NB-1:0] load_val = '0;

  gps_iq_collector #(.INTEG_BITS(W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ms0(ms0), .sout(sout), .shift(shift),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .fill(fill), .ovr_cnt(ovr_cnt), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Demod channel: reloads two cycles after ms0, shifts MSB-first on each strobe.
  always @(posedge clk) begin
    ms0_d1 <= ms0;
    if (ms0_d1)     ser_iq <= load_val;
    else if (shift) ser_iq <= {ser_iq[NB-2:0], 1'b0};
  end
  assign sout = ser_iq[NB-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc >= track_from) begin
        if (shift) begin
          if (sh_first < 0) sh_first = cyc;
          sh_last = cyc;
          sh_cnt++;
        end
        if (m_valid && v_first < 0) v_first = cyc;
      end
      if (hold_chk) begin
        checkOutput("hold_data", m_data, hold_d);
        checkOutput("hold_idx", m_idx, hold_i);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("word_data", m_data, mon_e.d);
          checkOutput("word_idx", m_idx, mon_e.idx);
          checkOutput("word_last", m_last, mon_e.idx == 3'd5);
        end
      end
      hold_chk = m_valid && !m_ready;
      hold_d   = m_data;
      hold_i   = m_idx;
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Consumer ready: 0 = stalled, 1 = always ready, 2 = toggles every cycle.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ~m_ready;
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic track(input int from);
    track_from = from;
    sh_first = -1;
    sh_last  = -1;
    sh_cnt   = 0;
    v_first  = -1;
  endtask

  task automatic expect_rec(input int i);
    exp_t e;
    for (int j = 0; j < 6; j++) begin
      e.d   = vecs[i].exp[j];
      e.idx = 3'(j);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_epoch(input int i, input bit store, output int nn);
    load_val = vecs[i].rec;
    nn = cyc;
    track(nn + 1);
    ms0 = 1'b1;
    step(1);
    ms0 = 1'b0;
    if (store) expect_rec(i);
  endtask

  task automatic applyStimulus(input int i, input bit store, output int nn);
    start_epoch(i, store, nn);
    step(NB + 6);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin step(1); b++; end
    step(2);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_shift"}, shift, 0);
    checkOutput({tag, "_valid"}, m_valid, 0);
    checkOutput({tag, "_data"}, m_data, 0);
    checkOutput({tag, "_idx"}, m_idx, 0);
    checkOutput({tag, "_last"}, m_last, 0);
    checkOutput({tag, "_fill"}, fill, 0);
    checkOutput({tag, "_ovr"}, ovr_cnt, 0);
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    checkOutput("ovr_clear", ovr_cnt, 0);
  endtask

  initial begin
    vecs[0].rec = {20'h00001, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h00005, 20'h00000};
    vecs[0].exp = '{32'h00000001, 32'hFFFFFFFF, 32'h0007FFFF, 32'hFFF80000, 32'h00000005, 32'h00000000};
    vecs[1].rec = {20'h00123, 20'hABCDE, 20'h80001, 20'h7FFFE, 20'h00000, 20'hFFFFF};
    vecs[1].exp = '{32'h00000123, 32'hFFFABCDE, 32'hFFF80001, 32'h0007FFFE, 32'h00000000, 32'hFFFFFFFF};
    vecs[2].rec = {20'h55555, 20'hAAAAA, 20'h00001, 20'hFFFFE, 20'h40000, 20'hC0000};
    vecs[2].exp = '{32'h00055555, 32'hFFFAAAAA, 32'h00000001, 32'hFFFFFFFE, 32'h00040000, 32'hFFFC0000};
    vecs[3].rec = {20'h12345, 20'hFEDCB, 20'h0FFFF, 20'h8F0F0, 20'h00010, 20'hF0000};
    vecs[3].exp = '{32'h00012345, 32'hFFFFEDCB, 32'h0000FFFF, 32'hFFF8F0F0, 32'h00000010, 32'hFFFF0000};
    vecs[4].rec = {20'h00002, 20'hFFFFD, 20'h3ABCD, 20'hC4321, 20'h7FFFF, 20'h80000};
    vecs[4].exp = '{32'h00000002, 32'hFFFFFFFD, 32'h0003ABCD, 32'hFFFC4321, 32'h0007FFFF, 32'hFFF80000};
    vecs[5].rec = {20'h00ABC, 20'h9ABCD, 20'h11111, 20'hEEEEE, 20'h00007, 20'hFFFF8};
    vecs[5].exp = '{32'h00000ABC, 32'hFFF9ABCD, 32'h00011111, 32'hFFFEEEEE, 32'h00000007, 32'hFFFFFFF8};

    rst = 1'b1; en = 1'b1; ms0 = 1'b0; ovr_clr = 1'b0; ready_mode = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Single epoch: shift window, first-valid latency, word contents.
    goto_cycle(10);
    applyStimulus(0, 1, n);
    checkOutput("t1_shift_first", sh_first, n + 2);
    checkOutput("t1_shift_last", sh_last, n + 1 + NB);
    checkOutput("t1_shift_cnt", sh_cnt, NB);
    checkOutput("t1_valid_first", v_first, n + 3 + NB);
    drain();

    // Five epochs into a stalled consumer: four stored, one dropped.
    ready_mode = 0;
    for (int i = 1; i <= 5; i++) applyStimulus(i, i < 5, n);
    checkOutput("t2_fill_full", fill, 4);
    checkOutput("t2_ovr", ovr_cnt, 1);
    ready_mode = 1;
    drain();
    checkOutput("t2_fill_empty", fill, 0);
    clear_ovr();

    // Epoch restart 60 cycles in.
    start_epoch(1, 0, n);
    step(59);
    start_epoch(2, 1, n2);
    checkOutput("t3_restart_gap", n2 - n, 60);
    step(NB + 6);
    checkOutput("t3_shift_first", sh_first, n2 + 2);
    checkOutput("t3_shift_last", sh_last, n2 + 1 + NB);
    checkOutput("t3_shift_cnt", sh_cnt, NB);
    checkOutput("t3_valid_first", v_first, n2 + 3 + NB);
    checkOutput("t3_ovr", ovr_cnt, 1);
    drain();
    clear_ovr();

    // Disable at bit 50, then an epoch while disabled.
    start_epoch(3, 0, n);
    goto_cycle(n + 52);
    en = 1'b0;
    step(NB + 6);
    checkOutput("t4_shift_last", sh_last, n + 52);
    checkOutput("t4_shift_cnt", sh_cnt, 51);
    checkOutput("t4_fill", fill, 0);
    checkOutput("t4_ovr", ovr_cnt, 0);
    start_epoch(3, 0, n);
    step(NB + 6);
    checkOutput("t4_dis_shift_cnt", sh_cnt, 0);
    checkOutput("t4_dis_fill", fill, 0);
    en = 1'b1;

    // Reset mid-capture with two records queued and a nonzero overflow count.
    ready_mode = 0;
    applyStimulus(1, 0, n);
    start_epoch(2, 0, n);
    step(20);
    start_epoch(2, 0, n);
    step(NB + 6);
    checkOutput("t5_fill_pre", fill, 2);
    checkOutput("t5_ovr_pre", ovr_cnt, 1);
    start_epoch(3, 0, n);
    goto_cycle(n + 72);
    checkOutput("t5_shift_pre", shift, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_state("t5_rst");
    ready_mode = 1;
    applyStimulus(4, 1, n);
    checkOutput("t5_valid_first", v_first, n + 3 + NB);
    drain();

    // Saturate the overflow counter with back-to-back restarts.
    load_val = vecs[0].rec;
    for (int k = 0; k < 260; k++) begin
      ms0 = 1'b1;
      step(1);
      ms0 = 1'b0;
      step(1);
    end
    expect_rec(0);
    step(NB + 6);
    checkOutput("t6_ovr_sat", ovr_cnt, 255);
    drain();

    // Clear coincident with a restart increment.
    start_epoch(5, 0, n);
    step(10);
    ovr_clr = 1'b1;
    start_epoch(2, 1, n);
    ovr_clr = 1'b0;
    checkOutput("t6_clr_wins", ovr_cnt, 0);
    step(NB + 6);
    checkOutput("t6_ovr_after", ovr_cnt, 0);
    drain();

    // Toggling ready: every word exactly once, held steady while stalled.
    ready_mode = 2;
    for (int i = 3; i <= 5; i++) applyStimulus(i, 1, n);
    drain();
    checkOutput("t6_fill_end", fill, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
